// File: rtl/nova_io_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nova_io_pkg : Nova device-bus function codes, flag encodings and widths   |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
package nova_io_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEV_W  = 6;

  // One entry per value of bs_adr[6:7]; reads and writes share the code.
  typedef enum logic [1:0] {
    FN_CTL  = 2'b00,
    FN_DATA = 2'b01,
    FN_MASK = 2'b10,
    FN_HALT = 2'b11
  } bus_fn_e;

  typedef enum logic [1:0] {
    FLAG_NONE = 2'b00,
    FLAG_EN   = 2'b01,
    FLAG_DIS  = 2'b10,
    FLAG_RSVD = 2'b11
  } flag_ctl_e;

endpackage : nova_io_pkg
`default_nettype wire

// File: rtl/nova_prio_enc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nova_prio_enc : combinational lowest-index-wins priority encoder          |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module nova_prio_enc #(
  parameter int NUM_IRQ = 16
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [3:0]         idx
);

  // Scan downwards so the last hit written is the lowest set index.
  always_comb begin
    valid = |req;
    idx   = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 4'(i);
      end
    end
  end

endmodule : nova_prio_enc
`default_nettype wire

// File: rtl/nova_intr_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nova_intr_ctl : Nova bus CPU device with multi-channel priority interrupt |
// |                 controller, HALT, IORST pulse and switch register read    |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module nova_intr_ctl
  import nova_io_pkg::*;
#(
  parameter logic [DEV_W-1:0]  DEVICE_ADDR  = 6'o77,
  parameter int                NUM_IRQ      = 16,
  parameter logic [DEV_W-1:0]  CODE_BASE    = 6'o20,
  parameter logic [DATA_W-1:0] SWITCHES     = 16'h8010,
  parameter int                IORST_CYCLES = 4
) (
  input  logic                pclk,
  input  logic                prst,
  output logic                bs_rst,
  input  logic                bs_stb,
  input  logic                bs_we,
  input  logic [0:ADDR_W-1]   bs_adr,
  input  logic [0:DATA_W-1]   bs_din,
  output logic [0:DATA_W-1]   bs_dout,
  input  logic [NUM_IRQ-1:0]  irq_req,
  output logic                cntrl_intr,
  input  logic                cntrl_intr_ack,
  output logic                cntrl_halt,
  input  logic                cntrl_cont
);

  localparam int               CNT_W    = $clog2(IORST_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IORST_CYCLES);

  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic               int_en_q, int_en_d;
  logic               intr_q, intr_d;
  logic               halt_q, halt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  dout_q, dout_d;

  logic               w_hit;
  logic               w_iorst;
  bus_fn_e            w_fn;
  flag_ctl_e          w_flag;
  logic [NUM_IRQ-1:0] w_field;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_eligible;
  logic [NUM_IRQ-1:0] w_win_onehot;
  logic               w_valid;
  logic [3:0]         w_idx;
  logic [DEV_W-1:0]   w_code;

  assign w_hit      = bs_stb && (bs_adr[0:DEV_W-1] == DEVICE_ADDR);
  assign w_fn       = bus_fn_e'(bs_adr[DEV_W:ADDR_W-1]);
  assign w_flag     = flag_ctl_e'(bs_din[DATA_W-2:DATA_W-1]);
  assign w_iorst    = w_hit && !bs_we && (w_fn == FN_HALT);
  assign w_rise     = irq_req & ~irq_prev_q;
  assign w_eligible = pending_q & ~mask_q;

  // Channel i lives at bus bit [15-i], i.e. the numeric LSB end of the word.
  always_comb begin
    w_field = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_field[i] = bs_din[DATA_W-1-i];
    end
  end

  nova_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .req   (w_eligible),
    .valid (w_valid),
    .idx   (w_idx)
  );

  assign w_code       = CODE_BASE + {2'b00, w_idx};
  assign w_win_onehot = NUM_IRQ'(1) << w_idx;

  always_comb begin
    pending_d  = pending_q;
    mask_d     = mask_q;
    irq_prev_d = irq_req;
    int_en_d   = int_en_q;
    intr_d     = int_en_q && (|w_eligible);
    halt_d     = halt_q;
    count_d    = (count_q != '0) ? (count_q - CNT_W'(1)) : count_q;
    dout_d     = '0;

    if (cntrl_cont) begin
      halt_d = 1'b0;
    end

    if (w_hit && bs_we) begin
      case (w_fn)
        FN_CTL: begin
          case (w_flag)
            FLAG_EN:  int_en_d = 1'b1;
            FLAG_DIS: int_en_d = 1'b0;
            default:  ;
          endcase
        end
        FN_DATA: pending_d = pending_d & ~w_field;
        FN_MASK: mask_d    = w_field;
        FN_HALT: halt_d    = 1'b1;
      endcase
    end

    if (w_hit && !bs_we) begin
      case (w_fn)
        FN_CTL:  dout_d = {int_en_q, intr_q, halt_q, 13'b0};
        FN_DATA: dout_d = SWITCHES;
        FN_MASK: begin
          if (w_valid) begin
            dout_d    = {10'b0, w_code};
            pending_d = pending_d & ~w_win_onehot;
          end
        end
        FN_HALT: dout_d = '0;
      endcase
    end

    // New edges are applied after all clears so a coincident set survives.
    pending_d = pending_d | w_rise;

    if (intr_q && cntrl_intr_ack) begin
      int_en_d = 1'b0;
      intr_d   = 1'b0;
    end

    if (w_iorst) begin
      pending_d = '0;
      mask_d    = '0;
      int_en_d  = 1'b0;
      intr_d    = 1'b0;
      count_d   = CNT_LOAD;
    end
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      pending_q  <= '0;
      mask_q     <= '0;
      irq_prev_q <= '0;
      int_en_q   <= 1'b0;
      intr_q     <= 1'b0;
      halt_q     <= 1'b0;
      count_q    <= '0;
      dout_q     <= '0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      irq_prev_q <= irq_prev_d;
      int_en_q   <= int_en_d;
      intr_q     <= intr_d;
      halt_q     <= halt_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
    end
  end

  assign bs_rst     = prst | (count_q != '0);
  assign bs_dout    = dout_q;
  assign cntrl_intr = intr_q;
  assign cntrl_halt = halt_q;

endmodule : nova_intr_ctl
`default_nettype wire
